// File: rtl/cnn_stream_controller_if.sv
// Pixel-stream control bundle between a frame source and cnn_stream_controller.
// The source owns start/in_valid; the controller owns everything else.
interface cnn_stream_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic                 conv_en;
    logic                 win_valid;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] col_idx;
    logic [CNT_WIDTH-1:0] row_idx;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output start, in_valid,
        input  in_ready, conv_en, win_valid, out_valid,
        input  col_idx, row_idx, out_count, busy, frame_done
    );

    modport slave (
        input  start, in_valid,
        output in_ready, conv_en, win_valid, out_valid,
        output col_idx, row_idx, out_count, busy, frame_done
    );
endinterface

// File: rtl/cnn_stream_controller.sv
// Frame sequencer for the cnn convolution datapath: accepts raster pixels, flags
// strided window completions, delays them to line up with results, then drains.
module cnn_stream_controller #(
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int FILTER_SIZE  = 5,
    parameter int STRIDE       = 4,
    parameter int PIPE_LATENCY = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn_stream_controller_if.slave bus,
    output logic [1:0]            state_o
);
    // Handshake: a pixel transfers on any cycle where in_valid and in_ready are
    // both high; in_valid may drop at any time (a stall) and nothing advances.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CNT_WIDTH-1:0] COL_LAST   = CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST   = CNT_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] WIN_START  = CNT_WIDTH'(FILTER_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(PIPE_LATENCY - 1);
    localparam logic [PH_W-1:0]      PH_LAST    = PH_W'(STRIDE - 1);

    state_e                state_q;
    logic                  in_ready_q, busy_q, done_q;
    logic [CNT_WIDTH-1:0]  col_q, row_q, drain_q, out_cnt_q;
    logic [CNT_WIDTH-1:0]  col_d, row_d;
    logic [PH_W-1:0]       col_ph_q, row_ph_q, col_ph_d, row_ph_d;
    logic [PIPE_LATENCY-1:0] pipe_q, pipe_d;
    logic                  accept, conv_en, win_valid, col_wrap, last_px;

    assign accept    = in_ready_q & bus.in_valid;
    assign conv_en   = accept | (state_q == DRAIN);
    assign win_valid = accept & (row_q >= WIN_START) & (col_q >= WIN_START)
                     & (row_ph_q == '0) & (col_ph_q == '0);
    assign col_wrap  = (col_q == COL_LAST);
    assign last_px   = col_wrap & (row_q == ROW_LAST);
    assign col_d     = col_wrap ? '0 : col_q + CNT_WIDTH'(1);
    assign row_d     = row_q + CNT_WIDTH'(1);

    // Phase is 0 at the first full-window position and steps modulo STRIDE after it.
    assign col_ph_d = ((col_d == WIN_START) || (col_ph_q == PH_LAST)) ? '0 : col_ph_q + PH_W'(1);
    assign row_ph_d = ((row_d == WIN_START) || (row_ph_q == PH_LAST)) ? '0 : row_ph_q + PH_W'(1);

    // Top stage is out_valid itself; it clears whenever the datapath is not enabled.
    always_comb begin
        pipe_d = pipe_q;
        pipe_d[PIPE_LATENCY-1] = 1'b0;
        if (conv_en) begin
            pipe_d[0] = win_valid;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            col_ph_q   <= '0;
            row_ph_q   <= '0;
            drain_q    <= '0;
            out_cnt_q  <= '0;
            pipe_q     <= '0;
        end else begin
            pipe_q <= pipe_d;
            done_q <= 1'b0;
            if (pipe_q[PIPE_LATENCY-1] && (out_cnt_q != '1)) begin
                out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        col_q      <= '0;
                        row_q      <= '0;
                        col_ph_q   <= '0;
                        row_ph_q   <= '0;
                        drain_q    <= '0;
                        out_cnt_q  <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        col_q    <= col_d;
                        col_ph_q <= col_ph_d;
                        if (col_wrap) begin
                            row_q    <= row_d;
                            row_ph_q <= row_ph_d;
                        end
                        if (last_px) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                            drain_q    <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.conv_en    = conv_en;
    assign bus.win_valid  = win_valid;
    assign bus.out_valid  = pipe_q[PIPE_LATENCY-1];
    assign bus.col_idx    = col_q;
    assign bus.row_idx    = row_q;
    assign bus.out_count  = out_cnt_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign state_o        = state_q;
endmodule
